// File: rtl/issue_sequencer.sv
// Issue sequencer: steps each decoded instruction through its functional unit,
// handshakes slow/memory units, applies the r14 squash and strobes write-back.
module issue_sequencer #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  input  logic        inst_cond,
  input  logic        r14_zero,
  input  logic        arithmetic,
  input  logic        slow_arithmetic,
  input  logic        logical,
  input  logic        memory,
  input  logic        wb_req,
  input  logic        slow_done,
  input  logic        mem_ack,
  input  logic        err_clr,
  output logic        inst_ready,
  output logic [3:0]  fu_en,
  output logic        slow_start,
  output logic        mem_req,
  output logic        wb_en,
  output logic        busy,
  output logic        err,
  output logic [15:0] retire_cnt
);

  localparam int unsigned FU_W  = 4;
  localparam int unsigned WD_W  = 8;
  localparam int unsigned CNT_W = 16;

  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(WAIT_MAX - 1);
  localparam logic [FU_W-1:0] FU_ARITH = 4'b0001;
  localparam logic [FU_W-1:0] FU_SLOW  = 4'b0010;
  localparam logic [FU_W-1:0] FU_LOGIC = 4'b0100;
  localparam logic [FU_W-1:0] FU_MEM   = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SLOW,
    S_MEM,
    S_WB
  } state_t;

  state_t            state_q, state_d;
  logic [FU_W-1:0]   sel_q, sel_d;
  logic              wbreq_q, wbreq_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [FU_W-1:0]   flags;
  logic              accept;
  logic              squash;
  logic              multi;
  logic              err_set;
  logic [FU_W-1:0]   fu_en_d;
  logic              slow_start_d;
  logic              mem_req_d;
  logic              wb_en_d;
  logic              retire_d;

  assign flags = {memory, logical, slow_arithmetic, arithmetic};

  // Next state, latched operation and next-cycle output values
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    wbreq_d      = wbreq_q;
    wd_d         = wd_q;
    err_set      = 1'b0;
    accept       = inst_valid & inst_ready;
    squash       = inst_cond & ~r14_zero;
    multi        = (flags & (flags - 4'd1)) != 4'd0;
    fu_en_d      = '0;
    slow_start_d = 1'b0;
    mem_req_d    = 1'b0;
    wb_en_d      = 1'b0;
    retire_d     = 1'b0;

    case (state_q)
      S_SLOW: begin
        if (slow_done) begin
          state_d = S_WB;
        end else if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          state_d = S_WB;
        end else if (wd_q == WD_LAST) begin
          state_d = S_IDLE;
          err_set = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (accept) begin
          err_set = multi;
          wbreq_d = wb_req & ~squash & (flags != 4'd0);
          wd_d    = '0;
          // Squashed and reserved instructions still pass through EXEC to retire
          if (squash || (flags == 4'd0)) begin
            state_d = S_EXEC;
            sel_d   = '0;
          end else if (memory) begin
            state_d = S_MEM;
            sel_d   = FU_MEM;
          end else if (slow_arithmetic) begin
            state_d = S_SLOW;
            sel_d   = FU_SLOW;
          end else if (arithmetic) begin
            state_d = S_EXEC;
            sel_d   = FU_ARITH;
          end else begin
            state_d = S_EXEC;
            sel_d   = FU_LOGIC;
          end
        end
      end
    endcase

    case (state_d)
      S_EXEC, S_WB: begin
        fu_en_d  = sel_d;
        wb_en_d  = wbreq_d;
        retire_d = 1'b1;
      end
      S_SLOW: begin
        fu_en_d      = FU_SLOW;
        slow_start_d = (state_q != S_SLOW);
      end
      S_MEM: begin
        fu_en_d   = FU_MEM;
        mem_req_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched operation and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      wbreq_q    <= 1'b0;
      wd_q       <= '0;
      inst_ready <= 1'b1;
      fu_en      <= '0;
      slow_start <= 1'b0;
      mem_req    <= 1'b0;
      wb_en      <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      wbreq_q    <= wbreq_d;
      wd_q       <= wd_d;
      inst_ready <= (state_d != S_SLOW) && (state_d != S_MEM);
      fu_en      <= fu_en_d;
      slow_start <= slow_start_d;
      mem_req    <= mem_req_d;
      wb_en      <= wb_en_d;
      busy       <= (state_d != S_IDLE);
      retire_cnt <= retire_cnt + CNT_W'(retire_d);
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_issue_sequencer.sv
// Bench for issue_sequencer: fast-op vector table with a scoreboard queue, plus
// hand-written slow, memory, watchdog, async-reset and counter-wrap sequences.
module tb_issue_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, inst_valid, inst_cond, r14_zero;
  logic arithmetic, slow_arithmetic, logical, memory, wb_req;
  logic slow_done, mem_ack, err_clr;

  logic        inst_ready, slow_start, mem_req, wb_en, busy, err;
  logic [3:0]  fu_en;
  logic [15:0] retire_cnt;

  logic        w_inst_ready, w_slow_start, w_mem_req, w_wb_en, w_busy, w_err;
  logic [3:0]  w_fu_en;
  logic [15:0] w_retire_cnt;

  issue_sequencer dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_cond(inst_cond),
    .r14_zero(r14_zero), .arithmetic(arithmetic), .slow_arithmetic(slow_arithmetic),
    .logical(logical), .memory(memory), .wb_req(wb_req), .slow_done(slow_done),
    .mem_ack(mem_ack), .err_clr(err_clr), .inst_ready(inst_ready), .fu_en(fu_en),
    .slow_start(slow_start), .mem_req(mem_req), .wb_en(wb_en), .busy(busy),
    .err(err), .retire_cnt(retire_cnt)
  );

  issue_sequencer #(.WAIT_MAX(4)) dut_wd (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_cond(inst_cond),
    .r14_zero(r14_zero), .arithmetic(arithmetic), .slow_arithmetic(slow_arithmetic),
    .logical(logical), .memory(memory), .wb_req(wb_req), .slow_done(slow_done),
    .mem_ack(mem_ack), .err_clr(err_clr), .inst_ready(w_inst_ready), .fu_en(w_fu_en),
    .slow_start(w_slow_start), .mem_req(w_mem_req), .wb_en(w_wb_en), .busy(w_busy),
    .err(w_err), .retire_cnt(w_retire_cnt)
  );

  typedef struct {
    logic       cond;
    logic       r14z;
    logic [3:0] flags;   // {memory, logical, slow, arith}
    logic       wbreq;
    logic [3:0] exp_fu;
    logic       exp_wb;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [3:0]  fu;
    logic        wb;
    logic        er;
    logic [15:0] ret;
  } exp_t;

  vec_t        tbl [8];
  exp_t        sb [$];
  exp_t        e;
  logic [15:0] model_ret;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic c, input logic z,
                       input logic [3:0] fl, input logic wr);
    inst_valid      = v;
    inst_cond       = c;
    r14_zero        = z;
    memory          = fl[3];
    logical         = fl[2];
    slow_arithmetic = fl[1];
    arithmetic      = fl[0];
    wb_req          = wr;
  endtask

  task automatic idle_in;
    drive(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic do_reset;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    model_ret = '0;
  endtask

  initial begin
    idle_in();
    slow_done = 1'b0;
    mem_ack   = 1'b0;
    err_clr   = 1'b0;
    model_ret = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;

    // cond, r14z, flags, wbreq, exp_fu, exp_wb, exp_err
    tbl[0] = '{1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1};

    repeat (2) tick;
    check("rst inst_ready", 32'(inst_ready), 1);
    check("rst fu_en", 32'(fu_en), 0);
    check("rst busy", 32'(busy), 0);
    check("rst wb_en", 32'(wb_en), 0);
    check("rst retire_cnt", 32'(retire_cnt), 0);
    rst_n = 1'b1;
    tick;

    // Back-to-back fast ops, one accept per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].cond, tbl[i].r14z, tbl[i].flags, tbl[i].wbreq);
      model_ret = model_ret + 16'd1;
      sb.push_back('{tbl[i].exp_fu, tbl[i].exp_wb, tbl[i].exp_err, model_ret});
      tick;
      e = sb.pop_front();
      check($sformatf("vec%0d fu_en", i), 32'(fu_en), 32'(e.fu));
      check($sformatf("vec%0d wb_en", i), 32'(wb_en), 32'(e.wb));
      check($sformatf("vec%0d err", i), 32'(err), 32'(e.er));
      check($sformatf("vec%0d retire_cnt", i), 32'(retire_cnt), 32'(e.ret));
    end
    idle_in();
    tick;
    check("fast idle busy", 32'(busy), 0);
    check("fast idle fu_en", 32'(fu_en), 0);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("err_clr", 32'(err), 0);

    // Slow op: accept at cycle 1, slow_done at cycle 9
    drive(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    tick;
    idle_in();
    check("slow c2 slow_start", 32'(slow_start), 1);
    check("slow c2 fu_en", 32'(fu_en), 32'h2);
    check("slow c2 inst_ready", 32'(inst_ready), 0);
    for (int c = 3; c <= 9; c++) begin
      tick;
      check($sformatf("slow c%0d slow_start", c), 32'(slow_start), 0);
      check($sformatf("slow c%0d inst_ready", c), 32'(inst_ready), 0);
      check($sformatf("slow c%0d wb_en", c), 32'(wb_en), 0);
    end
    slow_done = 1'b1;
    tick;
    slow_done = 1'b0;
    model_ret = model_ret + 16'd1;
    check("slow c10 wb_en", 32'(wb_en), 1);
    check("slow c10 fu_en", 32'(fu_en), 32'h2);
    check("slow c10 inst_ready", 32'(inst_ready), 1);
    check("slow c10 retire_cnt", 32'(retire_cnt), 32'(model_ret));
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    tick;
    idle_in();
    model_ret = model_ret + 16'd1;
    check("after slow fu_en", 32'(fu_en), 32'h1);
    check("after slow wb_en", 32'(wb_en), 1);
    check("after slow retire_cnt", 32'(retire_cnt), 32'(model_ret));
    tick;

    // Stray done/ack while idle
    slow_done = 1'b1;
    mem_ack   = 1'b1;
    tick;
    slow_done = 1'b0;
    mem_ack   = 1'b0;
    tick;
    check("stray busy", 32'(busy), 0);
    check("stray wb_en", 32'(wb_en), 0);

    // Memory ops with ack in the first MEM cycle, wb_req 1 then 0
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b0, 4'b1000, (k == 0));
      tick;
      idle_in();
      check($sformatf("mem%0d req", k), 32'(mem_req), 1);
      check($sformatf("mem%0d fu_en", k), 32'(fu_en), 32'h8);
      check($sformatf("mem%0d inst_ready", k), 32'(inst_ready), 0);
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      model_ret = model_ret + 16'd1;
      check($sformatf("mem%0d req drop", k), 32'(mem_req), 0);
      check($sformatf("mem%0d wb_en", k), 32'(wb_en), (k == 0) ? 1 : 0);
      check($sformatf("mem%0d retire_cnt", k), 32'(retire_cnt), 32'(model_ret));
      tick;
    end

    // Watchdog abort with WAIT_MAX=4
    do_reset();
    check("wd start err", 32'(w_err), 0);
    drive(1'b1, 1'b0, 1'b0, 4'b0010, 1'b1);
    tick;
    idle_in();
    check("wd c2 slow_start", 32'(w_slow_start), 1);
    for (int c = 3; c <= 5; c++) begin
      tick;
      check($sformatf("wd c%0d busy", c), 32'(w_busy), 1);
      check($sformatf("wd c%0d wb_en", c), 32'(w_wb_en), 0);
    end
    tick;
    check("wd abort busy", 32'(w_busy), 0);
    check("wd abort err", 32'(w_err), 1);
    check("wd abort wb_en", 32'(w_wb_en), 0);
    check("wd abort fu_en", 32'(w_fu_en), 0);
    check("wd abort retire_cnt", 32'(w_retire_cnt), 0);
    check("wd abort inst_ready", 32'(w_inst_ready), 1);
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
    check("wd err_clr", 32'(w_err), 0);

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    tick;
    drive(1'b1, 1'b0, 1'b0, 4'b1000, 1'b1);
    tick;
    idle_in();
    tick;
    check("midmem req", 32'(mem_req), 1);
    check("midmem retire_cnt", 32'(retire_cnt), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async mem_req", 32'(mem_req), 0);
    check("async fu_en", 32'(fu_en), 0);
    check("async busy", 32'(busy), 0);
    check("async inst_ready", 32'(inst_ready), 1);
    check("async retire_cnt", 32'(retire_cnt), 0);
    #1 rst_n = 1'b1;
    tick;
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    check("post rst wb_en", 32'(wb_en), 0);
    check("post rst busy", 32'(busy), 0);

    // Retire counter wrap
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);
    for (int i = 0; i < 65535; i++) tick;
    check("wrap full", 32'(retire_cnt), 32'hFFFF);
    tick;
    idle_in();
    check("wrap zero", 32'(retire_cnt), 0);
    tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
